// File: rtl/dds_sweep_ctl.sv
// dds_sweep_ctl: frame-aligned DDS frequency sweep controller; define PHASE_RESET_EN to pulse dds_rst at sweep start
module dds_sweep_ctl (
  input  logic        dclk,
  input  logic        rstn,
  input  logic        iq,
  input  logic        req,
  output logic        ack,
  input  logic        abort,
  input  logic [31:0] f_start,
  input  logic [31:0] f_step,
  input  logic [15:0] n_steps,
  input  logic [15:0] dwell,
  output logic [31:0] frq,
  output logic        dds_rst,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_t;
  state_t state, state_nx;
  logic        arm, take, load_hit, run;
  logic [31:0] start_r, step_r;
  logic [15:0] steps_r, dwell_r, cnt;
  // state register
  always_ff @(posedge dclk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  // next state and decoded strobes; frame boundary is iq sampled high
  always_comb begin
    state_nx = state;
    take     = state == IDLE && req && arm;
    load_hit = state == LOAD && iq && !abort;
    run      = state == DWELL && iq && !abort;
    busy     = state != IDLE;
    done     = state == DONE;
    if (take) state_nx = LOAD;
    else if ((state == LOAD || state == DWELL) && abort) state_nx = IDLE;
    else if (load_hit) state_nx = DWELL;
    else if (run && cnt == 16'd1 && steps_r == 16'd0) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  // capture, frequency word and dwell/step counters; arm delays the first accept one edge past reset
  always_ff @(posedge dclk or negedge rstn)
    if (!rstn) begin
      arm     <= 1'b0;
      ack     <= 1'b0;
      start_r <= '0;
      step_r  <= '0;
      steps_r <= '0;
      dwell_r <= '0;
      cnt     <= '0;
      frq     <= '0;
    end else begin
      arm <= 1'b1;
      ack <= take;
      if (take) begin
        start_r <= f_start;
        step_r  <= f_step;
        steps_r <= n_steps;
        dwell_r <= dwell == 16'd0 ? 16'd1 : dwell;
      end
      if (load_hit) begin
        frq <= start_r;
        cnt <= dwell_r;
      end else if (run) begin
        if (cnt != 16'd1) cnt <= cnt - 16'd1;
        else if (steps_r != 16'd0) begin
          frq     <= frq + step_r;
          steps_r <= steps_r - 16'd1;
          cnt     <= dwell_r;
        end
      end
    end
`ifdef PHASE_RESET_EN
  logic [2:0] pr_cnt;
  // phase reset held for two frames from the load boundary
  always_ff @(posedge dclk or negedge rstn)
    if (!rstn) pr_cnt <= '0;
    else pr_cnt <= load_hit ? 3'd4 : pr_cnt - {2'b0, pr_cnt != 3'd0};
  assign dds_rst = pr_cnt != 3'd0;
`else
  assign dds_rst = 1'b0;
`endif
endmodule

// File: tb/tb_dds_sweep_ctl.sv
// tb_dds_sweep_ctl: directed self-checking bench for dds_sweep_ctl
module tb_dds_sweep_ctl;
  logic        dclk, rstn, iq, req, abort, ack, dds_rst, busy, done;
  logic [31:0] f_start, f_step, frq;
  logic [15:0] n_steps, dwell;
  int total = 0, bad = 0;

  dds_sweep_ctl dut (
    .dclk(dclk), .rstn(rstn), .iq(iq), .req(req), .ack(ack), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_steps(n_steps), .dwell(dwell),
    .frq(frq), .dds_rst(dds_rst), .busy(busy), .done(done)
  );

  initial begin
    dclk = 0;
    forever #5 dclk = ~dclk;
  end

  task automatic tick;
    @(posedge dclk);
    #1;
    iq = ~iq;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle_outputs(input string name);
    chk({name, "_ack"}, {31'b0, ack}, 0);
    chk({name, "_busy"}, {31'b0, busy}, 0);
    chk({name, "_done"}, {31'b0, done}, 0);
    chk({name, "_dds_rst"}, {31'b0, dds_rst}, 0);
  endtask

  task automatic start(input logic [31:0] st, input logic [31:0] sp, input logic [15:0] ns, input logic [15:0] dw);
    if (iq) tick();
    f_start = st; f_step = sp; n_steps = ns; dwell = dw; req = 1;
    tick();
    chk("start_ack", {31'b0, ack}, 1);
    chk("start_busy", {31'b0, busy}, 1);
    req = 0;
    f_start = ~st; f_step = ~sp; n_steps = ~ns; dwell = ~dw;
  endtask

  task automatic run_sweep(input logic [31:0] st, input logic [31:0] sp, input logic [15:0] ns, input logic [15:0] dw);
    int de, fr, idx, dones;
    logic [31:0] ef;
    logic er;
    de = dw == 0 ? 1 : int'(dw);
    fr = (int'(ns) + 1) * de;
    dones = 0;
    start(st, sp, ns, dw);
    for (int k = 1; k <= 2 * fr + 2; k++) begin
      tick();
      idx = (k - 1) / (2 * de);
      if (idx > int'(ns)) idx = int'(ns);
      ef = st + sp * 32'(idx);
`ifdef PHASE_RESET_EN
      er = k <= 4;
`else
      er = 1'b0;
`endif
      if (done) dones++;
      chk("sweep_frq", frq, ef);
      chk("sweep_done", {31'b0, done}, {31'b0, k == 2 * fr + 1});
      chk("sweep_busy", {31'b0, busy}, {31'b0, k <= 2 * fr + 1});
      chk("sweep_ack", {31'b0, ack}, 0);
      chk("sweep_dds_rst", {31'b0, dds_rst}, {31'b0, er});
    end
    chk("sweep_done_count", dones, 1);
  endtask

  task automatic test_reset;
    rstn = 0; req = 1;
    tick(); tick();
    idle_outputs("reset");
    chk("reset_frq", frq, 0);
    rstn = 1;
    tick();
    chk("post_reset_first_edge_ack", {31'b0, ack}, 0);
    chk("post_reset_first_edge_busy", {31'b0, busy}, 0);
    tick();
    chk("post_reset_second_edge_ack", {31'b0, ack}, 1);
    chk("post_reset_second_edge_busy", {31'b0, busy}, 1);
    req = 0; abort = 1;
    tick();
    abort = 0;
    chk("abort_in_load_busy", {31'b0, busy}, 0);
  endtask

  task automatic test_sweep;
    run_sweep(32'h0004_0000, 32'h0001_0000, 16'd3, 16'd2);
    chk("sweep_final_frq", frq, 32'h0007_0000);
  endtask

  task automatic test_wrap;
    start(32'hFFFF_0000, 32'h0002_0000, 16'd1, 16'd1);
    tick();
    chk("wrap_first", frq, 32'hFFFF_0000);
    tick(); tick();
    chk("wrap_second", frq, 32'h0001_0000);
    tick(); tick();
    chk("wrap_done", {31'b0, done}, 1);
    tick();
    chk("wrap_idle", {31'b0, busy}, 0);
    chk("wrap_hold", frq, 32'h0001_0000);
    run_sweep(32'hFFFF_0000, 32'h0002_0000, 16'd1, 16'd1);
  endtask

  task automatic test_abort;
    int dones;
    dones = 0;
    start(32'h0004_0000, 32'h0001_0000, 16'd3, 16'd2);
    for (int k = 1; k <= 5; k++) tick();
    chk("abort_pre_frq", frq, 32'h0005_0000);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_frq", frq, 32'h0005_0000);
    for (int k = 0; k < 12; k++) begin
      if (done) dones++;
      tick();
    end
    chk("abort_no_done", dones, 0);
    chk("abort_hold_frq", frq, 32'h0005_0000);
    start(32'h0004_0000, 32'h0001_0000, 16'd3, 16'd2);
    for (int k = 1; k <= 4; k++) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("abort_priority_frq", frq, 32'h0004_0000);
    chk("abort_priority_busy", {31'b0, busy}, 0);
  endtask

  task automatic test_req_held;
    int acks;
    acks = 0;
    start(32'h0000_1234, 32'h0000_0001, 16'd0, 16'd1);
    req = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (ack) acks++;
    end
    chk("held_no_extra_ack", acks, 0);
    chk("held_idle", {31'b0, busy}, 0);
    tick();
    chk("held_reack", {31'b0, ack}, 1);
    req = 0; abort = 1;
    tick();
    abort = 0;
    chk("held_cleanup", {31'b0, busy}, 0);
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    start(32'h0004_0000, 32'h0001_0000, 16'd3, 16'd2);
    for (int k = 1; k <= 6; k++) tick();
    #1 rstn = 0;
    #1;
    chk("async_frq", frq, 0);
    idle_outputs("async");
    tick();
    rstn = 1;
    for (int k = 0; k < 20; k++) begin
      if (done) dones++;
      tick();
    end
    chk("reset_mid_no_done", dones, 0);
    run_sweep(32'h0100_0000, 32'hFFFF_FF00, 16'd2, 16'd3);
  endtask

  task automatic test_dwell0;
    run_sweep(32'hABCD_0000, 32'h0000_0010, 16'd0, 16'd0);
    chk("dwell0_final_frq", frq, 32'hABCD_0000);
  endtask

  initial begin
    rstn = 0; iq = 0; req = 0; abort = 0;
    f_start = 0; f_step = 0; n_steps = 0; dwell = 0;
    test_reset();
    test_sweep();
    test_wrap();
    test_abort();
    test_req_held();
    test_reset_mid();
    test_dwell0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctl.md
DDS_SWEEP_CTL -- requirements
Module: dds_sweep_ctl

Interface
REQ-001 SHALL have port dclk, input, 1, DDS clock; all logic is on the rising edge.
REQ-002 SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port iq, input, 1, DDS I/Q phase; a frame boundary is a dclk edge at which iq is sampled 1.
REQ-004 SHALL have port req, input, 1, host request to start a sweep.
REQ-005 SHALL have port ack, output, 1, one-cycle pulse accepting req.
REQ-006 SHALL have port abort, input, 1, terminates any sweep in progress.
REQ-007 SHALL have port f_start, input, 32, start frequency word.
REQ-008 SHALL have port f_step, input, 32, signed two's-complement increment per step.
REQ-009 SHALL have port n_steps, input, 16, number of increments after the start word.
REQ-010 SHALL have port dwell, input, 16, frames per step.
REQ-011 SHALL have port frq, output, 32, registered frequency word driving the DDS.
REQ-012 SHALL have port dds_rst, output, 1, active-high phase reset driving the DDS rst.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse at sweep completion.

Function
REQ-015 SHALL implement the states IDLE, LOAD, DWELL and DONE.
REQ-016 SHALL, in IDLE with req=1, pulse ack on the next cycle, capture f_start, f_step, n_steps and dwell into internal registers, and enter LOAD; input changes after capture have no effect.
REQ-017 SHALL ignore req (no ack) in any state other than IDLE.
REQ-018 SHALL, in LOAD at the first frame boundary, set frq to the captured f_start, load the dwell counter with the captured dwell, and enter DWELL.
REQ-019 SHALL treat a captured dwell of 0 as 1.
REQ-020 SHALL, in DWELL, decrement the dwell counter at each frame boundary.
REQ-021 SHALL, when the dwell counter is 1 at a frame boundary and steps remain, set frq to frq+f_step modulo 2^32 (wrap-around permitted), decrement the remaining steps, and reload the dwell counter.
REQ-022 SHALL, when the dwell counter is 1 at a frame boundary and no steps remain, enter DONE.
REQ-023 SHALL, in DONE, pulse done for one cycle, enter IDLE on the next cycle, and hold frq.
REQ-024 SHALL, on abort=1 in LOAD or DWELL, enter IDLE on the next edge with frq held and no done pulse.
REQ-025 SHALL give abort priority over any frq update due on the same edge.
REQ-026 SHALL change frq only on frame boundaries, so that the I and Q samples of one frame always use one word.
REQ-027 SHALL, with n_steps=0, hold f_start for dwell frames and then complete.
REQ-028 SHALL hold the total sweep time at (n_steps+1)*max(dwell,1) frames measured from the LOAD boundary.

Reset
REQ-029 SHALL, while rstn=0, force state to IDLE, frq to 0, all counters to 0, and ack, done, busy and dds_rst to 0, independent of dclk.
REQ-030 SHALL, when rstn is asserted mid-sweep, abandon the sweep with no done pulse.
REQ-031 SHALL first accept req at the second dclk edge after rstn deasserts.

Configuration
REQ-032 SHALL, with PHASE_RESET_EN defined, assert dds_rst high for exactly 2 frames (4 dclk), starting at the LOAD frame boundary, so that the DDS phase accumulator restarts coherently at f_start.
REQ-033 SHALL, without PHASE_RESET_EN, drive dds_rst constant 0 with all other timing unchanged.

Verification
REQ-034 SHALL pass this scenario: iq toggling 1,0; req with f_start=0x00040000, f_step=0x00010000, n_steps=3, dwell=2 -> ack next cycle; frq sequence 0x00040000, 0x00050000, 0x00060000, 0x00070000, each held 2 frames (4 dclk); done pulses once after 8 frames.
REQ-035 SHALL pass this scenario: f_start=0xFFFF0000, f_step=0x00020000, n_steps=1, dwell=1 -> frq 0xFFFF0000 then 0x00010000 (wrap); done after 2 frames.
REQ-036 SHALL pass this scenario: abort in the 3rd frame of the REQ-034 sweep -> busy low next edge, frq holds 0x00050000, no done; a new req is then acked.
REQ-037 SHALL pass this scenario: req held high during a sweep -> exactly one ack; a second ack comes only after IDLE is re-entered.
REQ-038 SHALL pass this scenario: rstn low mid-sweep -> frq=0 and busy=0 immediately, without waiting for dclk; with PHASE_RESET_EN, dds_rst high for 4 dclk from the LOAD boundary of a fresh sweep, and 0 throughout without it.
REQ-039 SHALL pass this scenario: dwell=0, n_steps=0 -> f_start held 1 frame, then done.
